// File: rtl/vr_fifo_param.sv
// Parametrised valid/ready FIFO with occupancy level, almost-full/almost-empty flags and synchronous flush.
// Latency: a word pushed at edge N is at the head (data_out_vld=1) in cycle N+1. There is no fall-through.
// Backpressure: data_in_rdy=0 while full, even if a pop happens in the same cycle. The optional level_peak
//   output is enabled by defining FIFO_PEAK_EN.
module vr_fifo_param #(
  parameter  int DATA_W    = 16,
  parameter  int DEPTH     = 8,
  parameter  int AFULL_TH  = 6,
  parameter  int AEMPTY_TH = 1,
  localparam int LVL_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_vld,
  output logic              data_in_rdy,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_vld,
  input  logic              data_out_rdy,
  output logic [LVL_W-1:0]  level,
`ifdef FIFO_PEAK_EN
  output logic [LVL_W-1:0]  level_peak,
`endif
  output logic              almost_full,
  output logic              almost_empty
);

  // Pointers index 0..DEPTH-1 and wrap explicitly, so DEPTH need not be a power of two.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_AFULL = LVL_W'(AFULL_TH);
  localparam logic [LVL_W-1:0] LVL_AEMPT = LVL_W'(AEMPTY_TH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q,  level_d;

  logic push;
  logic pop;

  // Handshake decode. Flush drops both sides, so the upstream word is treated as not accepted.
  always_comb begin
    data_in_rdy  = (level_q != LVL_FULL);
    data_out_vld = (level_q != '0);
    push         = data_in_vld  & data_in_rdy  & ~flush;
    pop          = data_out_vld & data_out_rdy & ~flush;
  end

  // Next-state for the pointers and the occupancy counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        level_d = level_q + LVL_W'(1);
      end else if (pop && !push) begin
        level_d = level_q - LVL_W'(1);
      end
    end
  end

  // Control state register; asynchronous reset returns the FIFO to empty immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset. A write landing during reset is invisible because the pointers are held at 0.
  always_ff @(posedge clk) begin
    if (push && rstn) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  // Head-of-queue read is combinational. The output is forced to zero while empty, so reset shows 0.
  always_comb begin
    data_out = data_out_vld ? mem[rd_ptr_q] : '0;
  end

  // Flags derive straight from the level register, so they add no latency.
  always_comb begin
    level        = level_q;
    almost_full  = (level_q >= LVL_AFULL);
    almost_empty = (level_q <= LVL_AEMPT);
  end

`ifdef FIFO_PEAK_EN
  logic [LVL_W-1:0] peak_q, peak_d;

  // The high-water mark follows level_d, so it rises on the same edge as level.
  always_comb begin
    peak_d = peak_q;
    if (flush) begin
      peak_d = '0;
    end else if (level_d > peak_q) begin
      peak_d = level_d;
    end
  end

  // Peak register; it is cleared by both reset and flush.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign level_peak = peak_q;
`endif

  // Structural invariants: occupancy stays within bounds and pointers stay in range.
  a_level_bound : assert property (@(posedge clk) disable iff (!rstn) level_q <= LVL_FULL);
  a_wr_range    : assert property (@(posedge clk) disable iff (!rstn) wr_ptr_q <= PTR_LAST);
  a_rd_range    : assert property (@(posedge clk) disable iff (!rstn) rd_ptr_q <= PTR_LAST);

endmodule

// File: tb/tb_vr_fifo_param.sv
module tb_vr_fifo_param;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int LVL_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rstn;
  logic              flush;
  logic [DATA_W-1:0] data_in;
  logic              data_in_vld;
  logic              data_in_rdy;
  logic [DATA_W-1:0] data_out;
  logic              data_out_vld;
  logic              data_out_rdy;
  logic [LVL_W-1:0]  level;
  logic              almost_full;
  logic              almost_empty;
`ifdef FIFO_PEAK_EN
  logic [LVL_W-1:0]  level_peak;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] q [$];

  always #5 clk = ~clk;

  vr_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(6), .AEMPTY_TH(1)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .flush        (flush),
    .data_in      (data_in),
    .data_in_vld  (data_in_vld),
    .data_in_rdy  (data_in_rdy),
    .data_out     (data_out),
    .data_out_vld (data_out_vld),
    .data_out_rdy (data_out_rdy),
    .level        (level),
`ifdef FIFO_PEAK_EN
    .level_peak   (level_peak),
`endif
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_level"}, 32'(level), 32'd0);
    check({tag, "_in_rdy"}, 32'(data_in_rdy), 32'd1);
    check({tag, "_out_vld"}, 32'(data_out_vld), 32'd0);
    check({tag, "_aempty"}, 32'(almost_empty), 32'd1);
    check({tag, "_afull"}, 32'(almost_full), 32'd0);
    check({tag, "_dout"}, 32'(data_out), 32'd0);
  endtask

  task automatic push_n(input int n, input logic [DATA_W-1:0] base);
    data_out_rdy = 1'b0;
    for (int i = 0; i < n; i++) begin
      data_in     = base + DATA_W'(i);
      data_in_vld = 1'b1;
      step();
    end
    data_in_vld = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; data_in = '0; data_in_vld = 1'b0; data_out_rdy = 1'b0;

    // 1. Reset, then idle.
    #12;
    check_reset_vals("rst");
    rstn = 1'b1;
    step(); step();
    check_reset_vals("idle");

    // 2. Fill to full with the consumer stalled, then drain.
    for (int i = 1; i <= 8; i++) begin
      data_in = DATA_W'(i); data_in_vld = 1'b1;
      step();
      check($sformatf("fill_lvl%0d", i), 32'(level), 32'(i));
      check($sformatf("fill_af%0d", i), 32'(almost_full), (i >= 6) ? 32'd1 : 32'd0);
      check($sformatf("fill_ae%0d", i), 32'(almost_empty), (i <= 1) ? 32'd1 : 32'd0);
    end
    check("full_rdy", 32'(data_in_rdy), 32'd0);
    data_in = 16'h0009; step();
    check("ninth_ignored", 32'(level), 32'd8);
    // Full with a pop in the same cycle: the push is still refused.
    data_in = 16'h0099; data_out_rdy = 1'b1;
    check("full_pop_rdy", 32'(data_in_rdy), 32'd0);
    check("drain_d1", 32'(data_out), 32'd1);
    step();
    check("full_pop_lvl", 32'(level), 32'd7);
    data_in_vld = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      check($sformatf("drain_vld%0d", i), 32'(data_out_vld), 32'd1);
      check($sformatf("drain_d%0d", i), 32'(data_out), 32'(i));
      step();
    end
    check("drained_lvl", 32'(level), 32'd0);
    check("drained_vld", 32'(data_out_vld), 32'd0);
    check("drained_dout", 32'(data_out), 32'd0);

    // 3. A single push into an empty FIFO, with the consumer ready in the same cycle.
    data_in = 16'hA5A5; data_in_vld = 1'b1; data_out_rdy = 1'b1;
    check("lat_vld_before", 32'(data_out_vld), 32'd0);
    step();
    data_in_vld = 1'b0; data_out_rdy = 1'b0;
    check("lat_vld_after", 32'(data_out_vld), 32'd1);
    check("lat_dout", 32'(data_out), 32'hA5A5);
    check("lat_lvl", 32'(level), 32'd1);
    data_out_rdy = 1'b1; step(); data_out_rdy = 1'b0;
    check("lat_pop_lvl", 32'(level), 32'd0);

    // 4. Steady state at level 4, pushing and popping every cycle. The pointers wrap.
    q.delete();
    for (int i = 0; i < 4; i++) q.push_back(16'h0010 + DATA_W'(i));
    push_n(4, 16'h0010);
    check("ss_lvl_start", 32'(level), 32'd4);
    for (int i = 0; i < 20; i++) begin
      data_in = 16'h0100 + DATA_W'(i); data_in_vld = 1'b1; data_out_rdy = 1'b1;
      check($sformatf("ss_head%0d", i), 32'(data_out), 32'(q[0]));
      void'(q.pop_front());
      q.push_back(data_in);
      step();
      check($sformatf("ss_lvl%0d", i), 32'(level), 32'd4);
    end
    data_in_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ss_tail%0d", i), 32'(data_out), 32'(q[0]));
      void'(q.pop_front());
      step();
    end
    data_out_rdy = 1'b0;
    check("ss_empty", 32'(level), 32'd0);

    // 5. Flush at level 5 with both handshakes offered. The pushed word is lost.
    push_n(5, 16'h0200);
    check("fl_pre_lvl", 32'(level), 32'd5);
    flush = 1'b1; data_in = 16'hDEAD; data_in_vld = 1'b1; data_out_rdy = 1'b1;
    step();
    flush = 1'b0; data_in_vld = 1'b0; data_out_rdy = 1'b0;
    check("fl_lvl", 32'(level), 32'd0);
    check("fl_vld", 32'(data_out_vld), 32'd0);
    check("fl_ae", 32'(almost_empty), 32'd1);
    step();
    check("fl_lost", 32'(level), 32'd0);
    push_n(1, 16'h7777);
    check("fl_next_head", 32'(data_out), 32'h7777);
    data_out_rdy = 1'b1; step(); data_out_rdy = 1'b0;

`ifdef FIFO_PEAK_EN
    // 6. The peak tracks the high-water mark and clears on flush.
    flush = 1'b1; step(); flush = 1'b0;
    check("pk_flush0", 32'(level_peak), 32'd0);
    push_n(7, 16'h0300);
    check("pk_fill", 32'(level_peak), 32'd7);
    data_out_rdy = 1'b1;
    for (int i = 0; i < 5; i++) step();
    data_out_rdy = 1'b0;
    check("pk_drain_lvl", 32'(level), 32'd2);
    check("pk_hold", 32'(level_peak), 32'd7);
    flush = 1'b1; step(); flush = 1'b0;
    check("pk_clear", 32'(level_peak), 32'd0);
`endif

    // Reset asserted mid-burst, away from any clock edge, takes effect at once.
    data_in = 16'h0400; data_in_vld = 1'b1;
    step(); step(); step();
    check("mid_lvl_pre", 32'(level), 32'd3);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_vals("mid_rst");
`ifdef FIFO_PEAK_EN
    check("mid_rst_peak", 32'(level_peak), 32'd0);
`endif
    step();
    check_reset_vals("mid_rst_hold");
    data_in_vld = 1'b0;
    rstn = 1'b1;
    step();
    check_reset_vals("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
